// File: rtl/ascon_pkg.sv
// Shared constants and FSM encoding for the Ascon-Hash message padder.
package ascon_pkg;
    localparam int         RATE_BW  = 64;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        EMIT  = 2'd1,
        EXTRA = 2'd2
    } pad_state_e;
endpackage

// File: rtl/ascon_msg_padder_if.sv
// Byte-stream input and rate-block output bundle of the padder.
// Optional blk_idx present when ASCON_PAD_BLKCNT_EN is defined.
interface ascon_msg_padder_if #(parameter int BW = ascon_pkg::RATE_BW) ();
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_empty;
    logic          in_ready;
    logic [BW-1:0] blk_data;
    logic          blk_valid;
    logic          blk_first;
    logic          blk_last;
    logic          blk_ready;
    logic [7:0]    m_length;
    logic          len_ovf;
`ifdef ASCON_PAD_BLKCNT_EN
    logic [7:0]    blk_idx;
`endif

    modport slave (
        input  in_data, in_valid, in_last, in_empty, blk_ready,
        output in_ready, blk_data, blk_valid, blk_first, blk_last, m_length, len_ovf
`ifdef ASCON_PAD_BLKCNT_EN
        , output blk_idx
`endif
    );

    modport master (
        output in_data, in_valid, in_last, in_empty, blk_ready,
        input  in_ready, blk_data, blk_valid, blk_first, blk_last, m_length, len_ovf
`ifdef ASCON_PAD_BLKCNT_EN
        , input blk_idx
`endif
    );
endinterface

// File: rtl/ascon_byte_packer.sv
// Big-endian byte lane writer with lane index and 0x80/zero pad fill.
module ascon_byte_packer
    import ascon_pkg::*;
#(
    parameter int BW = RATE_BW,
    localparam int NB = BW / 8,
    localparam int IW = $clog2(NB + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pad,
    input  logic          load_pad,
    input  logic [7:0]    byte_in,
    output logic [BW-1:0] data,
    output logic          full
);
    logic [BW-1:0] data_q, data_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] k;

    always_comb begin
        k      = idx_q + IW'(push);
        data_d = data_q;
        idx_d  = k;
        for (int i = 0; i < NB; i++) begin
            if (push && IW'(i) == idx_q)
                data_d[BW-1-8*i -: 8] = byte_in;
            // Pad lands on the lane after the final byte; later lanes zeroed.
            if (pad && IW'(i) == k)
                data_d[BW-1-8*i -: 8] = PAD_BYTE;
            else if (pad && IW'(i) > k)
                data_d[BW-1-8*i -: 8] = 8'h00;
        end
        if (load_pad) begin
            data_d = {PAD_BYTE, {(BW-8){1'b0}}};
            idx_d  = '0;
        end
        if (clr) begin
            data_d = '0;
            idx_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            idx_q  <= '0;
        end else begin
            data_q <= data_d;
            idx_q  <= idx_d;
        end
    end

    assign data = data_q;
    assign full = (k == IW'(NB));
endmodule

// File: rtl/ascon_msg_padder.sv
// Ascon-Hash message padder: byte stream in, padded BW-bit rate blocks out.
// Optional block index output enabled by ASCON_PAD_BLKCNT_EN.
module ascon_msg_padder
    import ascon_pkg::*;
#(
    parameter int BW = RATE_BW
) (
    input  logic               clk,
    input  logic               rst,
    ascon_msg_padder_if.slave  bus
);
    pad_state_e state_q, state_d;
    logic       in_ready_q, in_ready_d;
    logic       blk_valid_q, blk_valid_d;
    logic       blk_first_q, blk_first_d;
    logic       blk_last_q, blk_last_d;
    logic [7:0] m_length_q, m_length_d;
    logic       len_ovf_q, len_ovf_d;
    logic       first_q, first_d;
    logic       new_msg_q, new_msg_d;
    logic       pad_pending_q, pad_pending_d;
    logic       acc, push, pad, consume, full, clr, load_pad;
`ifdef ASCON_PAD_BLKCNT_EN
    logic [7:0] blk_idx_q, blk_idx_d;
`endif

    assign acc     = (state_q == FILL) && in_ready_q && bus.in_valid;
    assign push    = acc && !(bus.in_last && bus.in_empty);
    assign pad     = acc && bus.in_last;
    assign consume = blk_valid_q && bus.blk_ready;

    ascon_byte_packer #(.BW(BW)) u_packer (
        .clk(clk), .rst(rst), .clr(clr), .push(push), .pad(pad),
        .load_pad(load_pad), .byte_in(bus.in_data), .data(bus.blk_data), .full(full)
    );

    always_comb begin
        state_d       = state_q;
        blk_last_d    = blk_last_q;
        m_length_d    = m_length_q;
        len_ovf_d     = len_ovf_q;
        first_d       = first_q;
        new_msg_d     = new_msg_q;
        pad_pending_d = pad_pending_q;
        clr           = 1'b0;
        load_pad      = 1'b0;
        case (state_q)
            FILL: if (acc) begin
                if (new_msg_q) begin
                    len_ovf_d = 1'b0;
                    new_msg_d = 1'b0;
                end
                if (push) begin
                    if (m_length_q == 8'hFF) len_ovf_d  = 1'b1;
                    else                     m_length_d = m_length_q + 8'd1;
                end
                // A last byte that fills the block defers its pad to EXTRA.
                if (full) begin
                    state_d       = EMIT;
                    blk_last_d    = 1'b0;
                    pad_pending_d = pad;
                end else if (pad) begin
                    state_d    = EMIT;
                    blk_last_d = 1'b1;
                end
            end
            EMIT: if (consume) begin
                first_d = 1'b0;
                if (pad_pending_q) begin
                    state_d       = EXTRA;
                    load_pad      = 1'b1;
                    pad_pending_d = 1'b0;
                    blk_last_d    = 1'b1;
                end else begin
                    state_d = FILL;
                    clr     = 1'b1;
                    if (blk_last_q) begin
                        m_length_d = 8'd0;
                        first_d    = 1'b1;
                        new_msg_d  = 1'b1;
                        blk_last_d = 1'b0;
                    end
                end
            end
            EXTRA: if (consume) begin
                state_d    = FILL;
                clr        = 1'b1;
                m_length_d = 8'd0;
                first_d    = 1'b1;
                new_msg_d  = 1'b1;
                blk_last_d = 1'b0;
            end
            default: state_d = FILL;
        endcase
        in_ready_d  = (state_d == FILL);
        blk_valid_d = (state_d != FILL);
        blk_first_d = (state_d != FILL) && first_d;
    end

`ifdef ASCON_PAD_BLKCNT_EN
    always_comb begin
        blk_idx_d = blk_idx_q;
        if (consume)
            blk_idx_d = blk_last_q ? 8'd0 : (blk_idx_q == 8'hFF ? 8'hFF : blk_idx_q + 8'd1);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FILL;
            in_ready_q    <= 1'b0;
            blk_valid_q   <= 1'b0;
            blk_first_q   <= 1'b0;
            blk_last_q    <= 1'b0;
            m_length_q    <= 8'd0;
            len_ovf_q     <= 1'b0;
            first_q       <= 1'b1;
            new_msg_q     <= 1'b1;
            pad_pending_q <= 1'b0;
`ifdef ASCON_PAD_BLKCNT_EN
            blk_idx_q     <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            blk_valid_q   <= blk_valid_d;
            blk_first_q   <= blk_first_d;
            blk_last_q    <= blk_last_d;
            m_length_q    <= m_length_d;
            len_ovf_q     <= len_ovf_d;
            first_q       <= first_d;
            new_msg_q     <= new_msg_d;
            pad_pending_q <= pad_pending_d;
`ifdef ASCON_PAD_BLKCNT_EN
            blk_idx_q     <= blk_idx_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.blk_valid = blk_valid_q;
    assign bus.blk_first = blk_first_q;
    assign bus.blk_last  = blk_last_q;
    assign bus.m_length  = m_length_q;
    assign bus.len_ovf   = len_ovf_q;
`ifdef ASCON_PAD_BLKCNT_EN
    assign bus.blk_idx   = blk_idx_q;
`endif
endmodule
